// File: rtl/tipi_nibble_bus_master_pkg.sv
// Shared definitions for the TIPI nibble-bus master: register codes, the direction bit,
// the FSM state encoding and the latched request record.
package tipi_nibble_bus_master_pkg;

  localparam logic [1:0] TIPI_REG_TD = 2'd0;
  localparam logic [1:0] TIPI_REG_TC = 2'd1;
  localparam logic [1:0] TIPI_REG_RD = 2'd2;
  localparam logic [1:0] TIPI_REG_RC = 2'd3;

  localparam int TIPI_DIR_BIT = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_BRST, S_BRST_W,
    S_SEL_SU, S_SEL_HI, S_SEL_LO,
    S_WHI_SU, S_WHI_HI, S_WHI_LO,
    S_WLO_SU, S_WLO_HI, S_WLO_LO,
    S_TURN, S_RCLK_HI, S_RCLK_LO,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] rsel;
    logic [7:0] wdata;
  } req_t;

  function automatic logic is_write(input logic [1:0] rsel);
    return rsel[TIPI_DIR_BIT];
  endfunction

endpackage

// File: rtl/tipi_nibble_bus_master_phase_timer.sv
// Phase length down-counter: reloads to CLK_DIV-1 on phase entry, flags the final cycle.
module tipi_bus_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic last_cycle
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)          cnt <= '0;
    else if (load)       cnt <= 8'(CLK_DIV - 1);
    else if (cnt != '0)  cnt <= cnt - 8'd1;
  end

  assign last_cycle = (cnt == '0);

endmodule

// File: rtl/tipi_nibble_bus_master.sv
// TIPI 4-bit nibble-bus master: one byte register access per request, bus reset first.
// Define TIPI_NIBBLE_MASTER_STATS_EN to build the saturating completed-transaction counter.
module tipi_nibble_bus_master
  import tipi_nibble_bus_master_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_reg,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        bus_clk,
  output logic        bus_reset,
  output logic [3:0]  bus_data_o,
  output logic        bus_data_oe,
  input  logic [3:0]  bus_data_i,
  output logic [15:0] xfer_count
);

  state_t     state, state_nxt;
  req_t       req_q;
  logic [3:0] rd_hi;
  logic       last_cycle;

  logic       clk_nxt, brst_nxt, oe_nxt, rsp_nxt;
  logic [3:0] data_nxt;

  tipi_bus_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (state_nxt != state),
    .last_cycle (last_cycle)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_valid) state_nxt = S_BRST;
      S_BRST:    if (last_cycle) state_nxt = S_BRST_W;
      S_BRST_W:  if (last_cycle) state_nxt = S_SEL_SU;
      S_SEL_SU:  if (last_cycle) state_nxt = S_SEL_HI;
      S_SEL_HI:  if (last_cycle) state_nxt = S_SEL_LO;
      S_SEL_LO:  if (last_cycle) state_nxt = is_write(req_q.rsel) ? S_WHI_SU : S_TURN;
      S_WHI_SU:  if (last_cycle) state_nxt = S_WHI_HI;
      S_WHI_HI:  if (last_cycle) state_nxt = S_WHI_LO;
      S_WHI_LO:  if (last_cycle) state_nxt = S_WLO_SU;
      S_WLO_SU:  if (last_cycle) state_nxt = S_WLO_HI;
      S_WLO_HI:  if (last_cycle) state_nxt = S_WLO_LO;
      S_WLO_LO:  if (last_cycle) state_nxt = S_DONE;
      S_TURN:    if (last_cycle) state_nxt = S_RCLK_HI;
      S_RCLK_HI: if (last_cycle) state_nxt = S_RCLK_LO;
      S_RCLK_LO: if (last_cycle) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Bus pins are registered from the next state so they line up with the state register
  // and can be forced to their safe values by reset on the same edge.
  always_comb begin
    clk_nxt  = 1'b0;
    brst_nxt = 1'b0;
    oe_nxt   = 1'b0;
    rsp_nxt  = 1'b0;
    data_nxt = 4'h0;
    case (state_nxt)
      S_BRST:                       brst_nxt = 1'b1;
      S_SEL_SU, S_SEL_LO:           begin oe_nxt = 1'b1; data_nxt = {2'b00, req_q.rsel}; end
      S_SEL_HI:                     begin oe_nxt = 1'b1; data_nxt = {2'b00, req_q.rsel}; clk_nxt = 1'b1; end
      S_WHI_SU, S_WHI_LO:           begin oe_nxt = 1'b1; data_nxt = req_q.wdata[7:4]; end
      S_WHI_HI:                     begin oe_nxt = 1'b1; data_nxt = req_q.wdata[7:4]; clk_nxt = 1'b1; end
      S_WLO_SU, S_WLO_LO:           begin oe_nxt = 1'b1; data_nxt = req_q.wdata[3:0]; end
      S_WLO_HI:                     begin oe_nxt = 1'b1; data_nxt = req_q.wdata[3:0]; clk_nxt = 1'b1; end
      S_RCLK_HI:                    clk_nxt = 1'b1;
      S_DONE:                       rsp_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      req_q       <= '0;
      rd_hi       <= '0;
      rsp_rdata   <= '0;
      rsp_valid   <= 1'b0;
      bus_clk     <= 1'b0;
      bus_reset   <= 1'b1;
      bus_data_oe <= 1'b0;
      bus_data_o  <= '0;
    end else begin
      state       <= state_nxt;
      rsp_valid   <= rsp_nxt;
      bus_clk     <= clk_nxt;
      bus_reset   <= brst_nxt;
      bus_data_oe <= oe_nxt;
      bus_data_o  <= data_nxt;
      if (state == S_IDLE && req_valid) req_q <= '{rsel: req_reg, wdata: req_wdata};
      if (state == S_TURN && last_cycle) rd_hi <= bus_data_i;
      if (state == S_RCLK_LO && last_cycle) rsp_rdata <= {rd_hi, bus_data_i};
    end
  end

  assign req_ready = (state == S_IDLE) && reset;
  assign busy      = (state != S_IDLE);

`ifdef TIPI_NIBBLE_MASTER_STATS_EN
  logic [15:0] xfer_q;
  always_ff @(posedge clk) begin
    if (!reset)                                   xfer_q <= '0;
    else if (state == S_DONE && xfer_q != 16'hFFFF) xfer_q <= xfer_q + 16'd1;
  end
  assign xfer_count = xfer_q;
`else
  assign xfer_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tipi_nibble_bus_master.sv
// Bench for tipi_nibble_bus_master: two instances (CLK_DIV=2 and 1) each driving a
// behavioural nibble-bus slave; table of single transactions plus abort and back-to-back runs.
module tb_tipi_nibble_bus_master;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] req_valid, req_ready, rsp_valid, busy, bus_clk, bus_reset, bus_data_oe;
  logic [1:0] req_reg   [2];
  logic [7:0] req_wdata [2];
  logic [7:0] rsp_rdata [2];
  logic [3:0] bus_data_o[2];
  logic [3:0] bus_data_i[2];
  logic [15:0] xfer_count[2];

  always #5 clk = ~clk;

  tipi_nibble_bus_master #(.CLK_DIV(2)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_reg(req_reg[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .busy(busy[0]), .bus_clk(bus_clk[0]), .bus_reset(bus_reset[0]),
    .bus_data_o(bus_data_o[0]), .bus_data_oe(bus_data_oe[0]), .bus_data_i(bus_data_i[0]),
    .xfer_count(xfer_count[0]));

  tipi_nibble_bus_master #(.CLK_DIV(1)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_reg(req_reg[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .busy(busy[1]), .bus_clk(bus_clk[1]), .bus_reset(bus_reset[1]),
    .bus_data_o(bus_data_o[1]), .bus_data_oe(bus_data_oe[1]), .bus_data_i(bus_data_i[1]),
    .xfer_count(xfer_count[1]));

  // Slave: 1st rising bus_clk after reset latches the select nibble; reads then present
  // the high nibble, switching to the low nibble after the next rise; writes take two nibbles.
  logic [7:0] td [2];
  logic [7:0] tc [2];
  logic [7:0] rd_s[2] = '{8'h00, 8'h00};
  logic [7:0] rc_s[2] = '{8'h00, 8'h00};
  logic [1:0] sel [2] = '{2'd0, 2'd0};
  logic [1:0] cnt [2] = '{2'd0, 2'd0};
  logic [3:0] whi [2] = '{4'h0, 4'h0};
  logic [3:0] dq  [2] = '{4'h0, 4'h0};
  logic [1:0] bq = 2'b00, dqoe = 2'b00;
  int rises[2] = '{0, 0};
  int stab_err[2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus_reset[i] === 1'b1) begin
        cnt[i] <= 2'd0; sel[i] <= 2'd0; rises[i] <= 0;
      end else if (bus_clk[i] === 1'b1 && !bq[i]) begin
        rises[i] <= rises[i] + 1;
        if ((cnt[i] == 2'd0 || sel[i][1]) &&
            (!bus_data_oe[i] || !dqoe[i] || bus_data_o[i] !== dq[i]))
          stab_err[i] <= stab_err[i] + 1;
        case (cnt[i])
          2'd0: sel[i] <= bus_data_o[i][1:0];
          2'd1: if (sel[i][1]) whi[i] <= bus_data_o[i];
          2'd2: if (sel[i][1]) begin
                  if (sel[i][0]) rc_s[i] <= {whi[i], bus_data_o[i]};
                  else           rd_s[i] <= {whi[i], bus_data_o[i]};
                end
          default: ;
        endcase
        if (cnt[i] != 2'd3) cnt[i] <= cnt[i] + 2'd1;
      end
      bq[i]   <= bus_clk[i];
      dq[i]   <= bus_data_o[i];
      dqoe[i] <= bus_data_oe[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bus_data_i[i] = 4'h0;
      if (!sel[i][1] && cnt[i] == 2'd1) bus_data_i[i] = sel[i][0] ? tc[i][7:4] : td[i][7:4];
      if (!sel[i][1] && cnt[i] == 2'd2) bus_data_i[i] = sel[i][0] ? tc[i][3:0] : td[i][3:0];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_xfer(input int d, input logic [1:0] r, input logic [7:0] w,
                         output logic [7:0] rdata, output int lat, output int oecnt,
                         output bit got);
    @(negedge clk);
    chk("ready_before_req", req_ready[d], 1'b1);
    req_reg[d] = r; req_wdata[d] = w; req_valid[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    got = 0; lat = 0; oecnt = 0; rdata = 8'h00;
    for (int n = 1; n < 400; n++) begin
      if (bus_data_oe[d]) oecnt++;
      if (rsp_valid[d]) begin
        got = 1; lat = n; rdata = rsp_rdata[d];
        chk("busy_at_rsp", busy[d], 1'b1);
        break;
      end
      @(negedge clk);
    end
    chk("rsp_seen", got, 1'b1);
  endtask

  typedef struct {
    int d; logic [1:0] r; logic [7:0] w; logic [7:0] td; logic [7:0] tc;
    logic [7:0] exp; int lat; int rises; int oe;
  } vec_t;

  vec_t vt[8];
  logic [7:0] last_rd[2];

  task automatic chk_reset_state(input int d);
    chk("rst_req_ready", req_ready[d], 1'b0);
    chk("rst_rsp_valid", rsp_valid[d], 1'b0);
    chk("rst_rsp_rdata", rsp_rdata[d], 8'h00);
    chk("rst_busy", busy[d], 1'b0);
    chk("rst_bus_clk", bus_clk[d], 1'b0);
    chk("rst_bus_reset", bus_reset[d], 1'b1);
    chk("rst_oe", bus_data_oe[d], 1'b0);
    chk("rst_data_o", bus_data_o[d], 4'h0);
    chk("rst_xfer_count", xfer_count[d], 16'h0000);
  endtask

  initial begin
    logic [7:0] rdata;
    int lat, oecnt, nr, acc, viol;
    int rsp_t[3];
    logic [7:0] rsp_d[3];
    bit got, pb;

    vt[0] = '{0, 2'd0, 8'h00, 8'hA5, 8'h5A, 8'hA5, 17, 2, 6};
    vt[1] = '{0, 2'd1, 8'h00, 8'hA5, 8'h5A, 8'h5A, 17, 2, 6};
    vt[2] = '{0, 2'd2, 8'hA5, 8'hA5, 8'h5A, 8'hA5, 23, 3, 18};
    vt[3] = '{1, 2'd3, 8'h5A, 8'hC3, 8'h96, 8'h5A, 12, 3, 9};
    vt[4] = '{1, 2'd0, 8'h00, 8'hC3, 8'h96, 8'hC3, 9, 2, 3};
    vt[5] = '{1, 2'd1, 8'h00, 8'hC3, 8'h96, 8'h96, 9, 2, 3};
    vt[6] = '{0, 2'd3, 8'h3C, 8'hA5, 8'h5A, 8'h3C, 23, 3, 18};
    vt[7] = '{1, 2'd2, 8'hFF, 8'hC3, 8'h96, 8'hFF, 12, 3, 9};

    rst = 2'b00; req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_reg[i] = 2'd0; req_wdata[i] = 8'h00; td[i] = 8'h00; tc[i] = 8'h00; last_rd[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk_reset_state(0);
    chk_reset_state(1);
    rst = 2'b11;

    for (int i = 0; i < 8; i++) begin
      int d;
      d = vt[i].d;
      td[d] = vt[i].td; tc[d] = vt[i].tc;
      do_xfer(d, vt[i].r, vt[i].w, rdata, lat, oecnt, got);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_oe_cycles", i), oecnt, vt[i].oe);
      chk($sformatf("v%0d_rises", i), rises[d], vt[i].rises);
      chk($sformatf("v%0d_setup_stable", i), stab_err[d], 0);
      if (!vt[i].r[1]) begin
        chk($sformatf("v%0d_rdata", i), rdata, vt[i].exp);
        last_rd[d] = vt[i].exp;
      end else begin
        chk($sformatf("v%0d_slave_reg", i), vt[i].r[0] ? rc_s[d] : rd_s[d], vt[i].exp);
        chk($sformatf("v%0d_rdata_hold", i), rdata, last_rd[d]);
      end
    end

    // Abort during WHI_HI (second bus_clk rise of a write).
    @(negedge clk);
    req_reg[0] = 2'd2; req_wdata[0] = 8'h77; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    nr = 0; pb = bus_clk[0];
    for (int n = 0; n < 200 && nr < 2; n++) begin
      @(negedge clk);
      if (bus_clk[0] && !pb) nr++;
      pb = bus_clk[0];
    end
    chk("abort_reached_whi_hi", nr, 2);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("abort_bus_reset", bus_reset[0], 1'b1);
    chk("abort_oe", bus_data_oe[0], 1'b0);
    chk("abort_bus_clk", bus_clk[0], 1'b0);
    chk("abort_busy", busy[0], 1'b0);
    nr = 0;
    for (int n = 0; n < 4; n++) begin
      if (rsp_valid[0]) nr++;
      @(negedge clk);
    end
    chk("abort_no_rsp", nr, 0);
    chk("abort_slave_rd_untouched", rd_s[0], 8'hA5);
    rst[0] = 1'b1;
    td[0] = 8'h3C;
    do_xfer(0, 2'd0, 8'h00, rdata, lat, oecnt, got);
    chk("post_abort_rdata", rdata, 8'h3C);
    chk("post_abort_latency", lat, 17);

    // Three back-to-back reads with req_valid held high, from a fresh reset.
    @(negedge clk); rst[0] = 1'b0;
    @(negedge clk); rst[0] = 1'b1;
    req_reg[0] = 2'd0;
    @(negedge clk);
    req_valid[0] = 1'b1;
    acc = 0; nr = 0; viol = 0;
    for (int n = 0; n < 200; n++) begin
      if (req_valid[0] && req_ready[0]) acc++;
      if (busy[0] && req_ready[0]) viol++;
      if (rsp_valid[0]) begin rsp_t[nr] = n; rsp_d[nr] = rsp_rdata[0]; nr++; end
      if (nr == 3) break;
      @(negedge clk);
      if (acc == 3) req_valid[0] = 1'b0;
    end
    chk("b2b_rsp_count", nr, 3);
    chk("b2b_accepts", acc, 3);
    chk("b2b_ready_while_busy", viol, 0);
    if (nr == 3) begin
      chk("b2b_rsp0_time", rsp_t[0], 17);
      chk("b2b_rsp1_time", rsp_t[1], 35);
      chk("b2b_rsp2_time", rsp_t[2], 53);
      chk("b2b_rdata2", rsp_d[2], 8'h3C);
    end
    @(negedge clk);
    chk("b2b_idle_ready", req_ready[0], 1'b1);
`ifdef TIPI_NIBBLE_MASTER_STATS_EN
    chk("b2b_xfer_count", xfer_count[0], 16'd3);
`else
    chk("b2b_xfer_count_tied", xfer_count[0], 16'd0);
`endif
    @(negedge clk);
    chk("b2b_no_fourth", busy[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $fatal(1);
  end

endmodule
